// File: rtl/rate_down_counter.sv
// rate_down_counter: programmable down-counter that converts a free-running
// enable strobe into one-cycle terminal-count pulses (Tick).
// Load a reload value N, Start a countdown, and Tick fires after N+1
// enabled cycles.
//
// Optional feature macro: RATE_DOWN_COUNTER_AUTO_RELOAD_EN
//   defined     -> periodic mode: reload at terminal count, stay in RUN
//   not defined -> one-shot mode: park in DONE at terminal count
module rate_down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadValue,
  input  logic             Start,
  input  logic             Stop,
  input  logic             En,
  output logic [WIDTH-1:0] Count,
  output logic             Tick,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_next_count;
  logic [WIDTH-1:0] r_reload;
  logic [WIDTH-1:0] w_next_reload;
  logic             r_tick;
  logic             w_next_tick;

  // State, count, reload and tick registers with synchronous active-low reset.
  // NOTE: non-blocking assignments keep every register sampling the same
  // pre-edge values, so ordering inside this block does not matter.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_reload <= '0;
      r_tick   <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_count  <= w_next_count;
      r_reload <= w_next_reload;
      r_tick   <= w_next_tick;
    end
  end

  // Next-state and datapath decode; priority is Load > Stop > Start > En.
  // NOTE: every signal gets a default at the top so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state  = r_state;
    w_next_count  = r_count;
    w_next_reload = r_reload;
    w_next_tick   = 1'b0;

    if (Load) begin
      w_next_reload = LoadValue;
      w_next_count  = LoadValue;
      w_next_state  = S_IDLE;
    end else if (Stop) begin
      // Stop masks Start and En in every state; it only changes state in RUN.
      if (r_state == S_RUN) begin
        w_next_state = S_IDLE;
      end
    end else if (Start && (r_state != S_RUN)) begin
      w_next_count = r_reload;
      w_next_state = S_RUN;
    end else if ((r_state == S_RUN) && En) begin
      if (r_count != '0) begin
        w_next_count = r_count - WIDTH'(1);
      end else begin
        // Terminal count: pulse Tick for the following cycle.
        w_next_tick = 1'b1;
`ifdef RATE_DOWN_COUNTER_AUTO_RELOAD_EN
        w_next_count = r_reload;
        w_next_state = S_RUN;
`else
        w_next_count = '0;
        w_next_state = S_DONE;
`endif
      end
    end
  end

  // Output decode straight from the registers; no combinational input paths.
  always_comb begin
    Count = r_count;
    Tick  = r_tick;
    Busy  = (r_state == S_RUN);
    Done  = (r_state == S_DONE);
  end

endmodule

// File: tb/tb_rate_down_counter.sv
// Scoreboard bench for rate_down_counter. The driver applies one directed
// vector per clock and queues the hand-computed outputs expected after that
// edge; the monitor pops and compares one entry on each falling edge.
// Expectations follow RATE_DOWN_COUNTER_AUTO_RELOAD_EN when it is defined.
module tb_rate_down_counter;

`ifdef RATE_DOWN_COUNTER_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic       Load = 1'b0;
  logic [7:0] LoadValue = '0;
  logic       Start = 1'b0;
  logic       Stop = 1'b0;
  logic       En = 1'b0;
  logic [7:0] Count;
  logic       Tick;
  logic       Busy;
  logic       Done;

  typedef struct packed {
    logic [7:0] count;
    logic       tick;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    errors = 0;
  int    checks = 0;

  rate_down_counter #(.WIDTH(8)) dut (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .Load     (Load),
    .LoadValue(LoadValue),
    .Start    (Start),
    .Stop     (Stop),
    .En       (En),
    .Count    (Count),
    .Tick     (Tick),
    .Busy     (Busy),
    .Done     (Done)
  );

  initial forever #5 Clock = ~Clock;

  // Monitor: one expected entry per clock, compared away from the rising edge.
  always @(negedge Clock) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (Count !== e.count || Tick !== e.tick || Busy !== e.busy || Done !== e.done) begin
        errors++;
        $display("FAIL %s: got count=%0d tick=%b busy=%b done=%b, expected count=%0d tick=%b busy=%b done=%b",
                 nm, Count, Tick, Busy, Done, e.count, e.tick, e.busy, e.done);
      end
    end
  end

  // Apply one vector for the next rising edge and queue the outputs expected after it.
  task automatic step(input logic rstn, input logic ld, input logic [7:0] lv,
                      input logic st, input logic sp, input logic en,
                      input logic [7:0] ec, input logic et, input logic eb,
                      input logic ed, input string nm);
    exp_t e;
    @(negedge Clock);
    #1;
    Resetn    = rstn;
    Load      = ld;
    LoadValue = lv;
    Start     = st;
    Stop      = sp;
    En        = en;
    e.count = ec;
    e.tick  = et;
    e.busy  = eb;
    e.done  = ed;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Plain enabled/idle cycle with no control inputs.
  task automatic run(input logic en, input logic [7:0] ec, input logic et,
                     input logic eb, input logic ed, input string nm);
    step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, en, ec, et, eb, ed, nm);
  endtask

  initial begin
    // Reset held for two cycles with random control inputs.
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           8'd0, 1'b0, 1'b0, 1'b0, "reset");
    end

`ifndef RATE_DOWN_COUNTER_AUTO_RELOAD_EN
    // One-shot, N=3, En high: 3,2,1,0 then Tick with Done; Start repeats.
    step(1'b1, 1'b1, 8'd3, 1'b0, 1'b0, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0, "os_load3");
    for (int r = 0; r < 2; r++) begin
      step(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 8'd3, 1'b0, 1'b1, 1'b0, "os_start");
      run(1'b1, 8'd2, 1'b0, 1'b1, 1'b0, "os_cnt2");
      run(1'b1, 8'd1, 1'b0, 1'b1, 1'b0, "os_cnt1");
      run(1'b1, 8'd0, 1'b0, 1'b1, 1'b0, "os_cnt0");
      run(1'b1, 8'd0, 1'b1, 1'b0, 1'b1, "os_tick");
      run(1'b1, 8'd0, 1'b0, 1'b0, 1'b1, "os_done_hold");
    end
`else
    // Auto-reload, N=4, En high: Tick every 5 cycles for 4 periods.
    step(1'b1, 1'b1, 8'd4, 1'b0, 1'b0, 1'b1, 8'd4, 1'b0, 1'b0, 1'b0, "ar_load4");
    step(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 8'd4, 1'b0, 1'b1, 1'b0, "ar_start");
    for (int p = 0; p < 4; p++) begin
      for (int c = 3; c >= 0; c--) begin
        run(1'b1, 8'(c), 1'b0, 1'b1, 1'b0, "ar_count");
      end
      run(1'b1, 8'd4, 1'b1, 1'b1, 1'b0, "ar_tick");
    end
    step(1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 8'd4, 1'b0, 1'b0, 1'b0, "ar_stop");
`endif

    // Gapped enable, N=2: Count holds on En=0 cycles, Tick after 3 enabled cycles.
    step(1'b1, 1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0, "gap_load2");
    step(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 1'b1, 1'b0, "gap_start");
    run(1'b0, 8'd2, 1'b0, 1'b1, 1'b0, "gap_hold2");
    run(1'b1, 8'd1, 1'b0, 1'b1, 1'b0, "gap_dec1");
    run(1'b0, 8'd1, 1'b0, 1'b1, 1'b0, "gap_hold1");
    run(1'b1, 8'd0, 1'b0, 1'b1, 1'b0, "gap_dec0");
    run(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, "gap_hold0");
    run(1'b1, AUTO ? 8'd2 : 8'd0, 1'b1, AUTO, !AUTO, "gap_tick");
    step(1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, AUTO ? 8'd2 : 8'd0, 1'b0, 1'b0, !AUTO, "gap_after");

    // Stop at Count=5 holds the count in IDLE.
    step(1'b1, 1'b1, 8'd7, 1'b0, 1'b0, 1'b0, 8'd7, 1'b0, 1'b0, 1'b0, "ctl_load7");
    step(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd7, 1'b0, 1'b1, 1'b0, "ctl_start");
    run(1'b1, 8'd6, 1'b0, 1'b1, 1'b0, "ctl_dec6");
    run(1'b1, 8'd5, 1'b0, 1'b1, 1'b0, "ctl_dec5");
    step(1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 8'd5, 1'b0, 1'b0, 1'b0, "ctl_stop5");
    run(1'b1, 8'd5, 1'b0, 1'b0, 1'b0, "ctl_idle_hold5");
    // Start in RUN is ignored: no reload back to 7.
    step(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd7, 1'b0, 1'b1, 1'b0, "ctl_restart");
    run(1'b1, 8'd6, 1'b0, 1'b1, 1'b0, "ctl_dec6b");
    step(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd6, 1'b0, 1'b1, 1'b0, "ctl_start_in_run");
    // Load 9 on the terminal-count edge: no Tick, Count=9, IDLE.
    step(1'b1, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0, "ctl_load1");
    step(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 1'b1, 1'b0, "ctl_start1");
    run(1'b1, 8'd0, 1'b0, 1'b1, 1'b0, "ctl_dec0");
    step(1'b1, 1'b1, 8'd9, 1'b0, 1'b0, 1'b1, 8'd9, 1'b0, 1'b0, 1'b0, "ctl_load_on_tc");
    run(1'b1, 8'd9, 1'b0, 1'b0, 1'b0, "ctl_after_load");
    // Stop and Start together: Stop wins, in IDLE and in RUN.
    step(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 8'd9, 1'b0, 1'b0, 1'b0, "ctl_stopstart_idle");
    step(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd9, 1'b0, 1'b1, 1'b0, "ctl_start9");
    step(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 8'd9, 1'b0, 1'b0, 1'b0, "ctl_stopstart_run");

    // N=0: Tick on every enabled cycle in auto-reload, once then DONE in one-shot.
    step(1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, "n0_load");
    step(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, "n0_start");
    for (int i = 0; i < 4; i++) begin
      run(1'b1, 8'd0, (i == 0) || AUTO, AUTO, !AUTO, "n0_tick_run");
    end
    run(1'b0, 8'd0, 1'b0, AUTO, !AUTO, "n0_en_low");
    step(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, "n0_rearm");
    // Stop on the terminal-count edge suppresses Tick.
    step(1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, "n0_stop_on_tc");

    // Reset in the middle of a countdown clears everything with no Tick.
    step(1'b1, 1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 8'd5, 1'b0, 1'b0, 1'b0, "mr_load5");
    step(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 8'd5, 1'b0, 1'b1, 1'b0, "mr_start");
    run(1'b1, 8'd4, 1'b0, 1'b1, 1'b0, "mr_dec4");
    run(1'b1, 8'd3, 1'b0, 1'b1, 1'b0, "mr_dec3");
    step(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, "mr_reset");
    run(1'b1, 8'd0, 1'b0, 1'b0, 1'b0, "mr_after_reset");
    // Reset on a terminal-count edge also suppresses Tick.
    step(1'b1, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0, "mr_load1");
    step(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 1'b1, 1'b0, "mr_start1");
    run(1'b1, 8'd0, 1'b0, 1'b1, 1'b0, "mr_dec0");
    step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, "mr_reset_on_tc");
    run(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, "mr_final_idle");

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(negedge Clock);
    end
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
